// File: rtl/cpu_seq_ctrl.sv
// Eight-phase instruction sequencer for the accumulator core: fetch, decode, operand, execute, halt.
// Optional memory wait-state handling with bus timeout is built when CTRL_WAIT_EN is defined.
module cpu_seq_ctrl #(
  parameter int unsigned OP_W     = 3,
  parameter int unsigned CYC_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_rdy,
  input  logic             resume,
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             data_e,
  output logic             halt,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CYC_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    StFetchA = 3'd0,
    StFetchR = 3'd1,
    StFetchL = 3'd2,
    StDecode = 3'd3,
    StOpA    = 3'd4,
    StOpR    = 3'd5,
    StExec   = 3'd6,
    StHalted = 3'd7
  } state_e;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cnt_q;
  logic [2:0]       op_lo;
  logic             legal, alu_op, is_sto, is_jmp, is_skz, is_hlt;
  logic             stall, timeout;

  assign op_lo  = opcode[2:0];
  // Shift keeps the upper-bit check valid even when OP_W is exactly 3.
  assign legal  = ((opcode >> 3) == '0);
  assign alu_op = legal && (op_lo == OpAdd || op_lo == OpAnd || op_lo == OpXor ||
                            op_lo == OpLda);
  assign is_sto = legal && (op_lo == OpSto);
  assign is_jmp = legal && (op_lo == OpJmp);
  assign is_skz = legal && (op_lo == OpSkz);
  assign is_hlt = legal && (op_lo == OpHlt);

`ifdef CTRL_WAIT_EN
  localparam int unsigned WcW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [WcW-1:0] wait_q;
  logic           bus_err_q;
  logic           mem_phase;

  assign mem_phase = (state_q == StFetchR) || (state_q == StOpR && (alu_op || is_sto));
  assign stall     = mem_phase && !mem_rdy;
  assign timeout   = stall && (wait_q == WcW'(WAIT_MAX - 1));
  assign bus_err   = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (timeout || !stall) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_q + 1'b1;
      end
      if (timeout) begin
        bus_err_q <= 1'b1;
      end else if (state_q == StHalted && resume) begin
        bus_err_q <= 1'b0;
      end
    end
  end
`else
  localparam int unsigned UnusedWaitMax = WAIT_MAX;
  logic unused_mem_rdy;

  assign unused_mem_rdy = mem_rdy;
  assign stall          = 1'b0;
  assign timeout        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetchA: state_d = StFetchR;
      StFetchR: state_d = StFetchL;
      StFetchL: state_d = StDecode;
      StDecode: state_d = is_hlt ? StHalted : StOpA;
      StOpA:    state_d = StOpR;
      StOpR:    state_d = StExec;
      StExec:   state_d = StFetchA;
      StHalted: state_d = resume ? StFetchA : StHalted;
      default:  state_d = StFetchA;
    endcase
    // A stalled memory phase holds unless it has timed out.
    if (stall) begin
      state_d = timeout ? StHalted : state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetchA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StExec) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    ld_ir   = 1'b0;
    ld_ac   = 1'b0;
    ld_pc   = 1'b0;
    inc_pc  = 1'b0;
    data_e  = 1'b0;
    halt    = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      StFetchA: sel = 1'b1;
      StFetchR: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      StFetchL: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      StDecode: begin
        inc_pc  = 1'b1;
        illegal = !legal;
      end
      StOpA:    rd = alu_op;
      StOpR: begin
        rd     = alu_op;
        wr     = is_sto;
        data_e = is_sto;
      end
      StExec: begin
        rd     = alu_op;
        ld_ac  = alu_op;
        data_e = is_sto;
        ld_pc  = is_jmp;
        inc_pc = is_skz && zero;
      end
      StHalted: halt = 1'b1;
      default:  sel = 1'b1;
    endcase
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
